mem_arbiter: RTL

- Three-master, one-slave arbiter that shares the DDR2 memory port of quasi_main between:
  - the CPU (m0),
  - the DMA/peripheral engine (m1),
  - the video/framebuffer fetcher (m2).
- Grants are round-robin. One transaction is outstanding at a time.
- A timeout watchdog protects masters against a hung memory controller.
- Sits between the bus interconnect and the DDR2 controller's simple a/d/we/rd/spo/ready interface.

---
 rtl/mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one DDR2 a/d/we/rd/spo/ready port
//               between three masters (m0 = CPU, m1 = DMA, m2 = video).
//               One transaction is in flight at a time; a watchdog aborts a
//               transaction the memory controller never answers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   mK_a / mK_d               master K address / write data (sampled in IDLE)
//   mK_we / mK_rd             master K write / read request levels (we wins)
//   mK_spo / mK_ready         master K read data / one-cycle completion pulse
//   s_a / s_d                 slave address / write data (stable in WAIT)
//   s_we / s_rd               one-cycle slave write / read strobes
//   s_spo / s_ready           slave read data / completion pulse
//   timeout_err               sticky watchdog-abort flag
//   grant                     current owner 0..2, 3 when idle
// ============================================================================
module mem_arbiter #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TIMEOUT  = 4096,
    parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEADBEEF)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] m0_a,
    input  logic [AW-1:0] m1_a,
    input  logic [AW-1:0] m2_a,
    input  logic [DW-1:0] m0_d,
    input  logic [DW-1:0] m1_d,
    input  logic [DW-1:0] m2_d,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic          m2_we,
    input  logic          m0_rd,
    input  logic          m1_rd,
    input  logic          m2_rd,
    output logic [DW-1:0] m0_spo,
    output logic [DW-1:0] m1_spo,
    output logic [DW-1:0] m2_spo,
    output logic          m0_ready,
    output logic          m1_ready,
    output logic          m2_ready,
    output logic [AW-1:0] s_a,
    output logic [DW-1:0] s_d,
    output logic          s_we,
    output logic          s_rd,
    input  logic [DW-1:0] s_spo,
    input  logic          s_ready,
    output logic          timeout_err,
    output logic [1:0]    grant
);

    localparam int            CW     = $clog2(TIMEOUT);
    // Watchdog trips when the counter reaches this value; it also saturates here.
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]    C_IDLE_GRANT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q,  last_d;
    logic [1:0]    grant_q, grant_d;
    logic [AW-1:0] s_a_q,   s_a_d;
    logic [DW-1:0] s_d_q,   s_d_d;
    logic          op_we_q, op_we_d;
    logic          s_we_q,  s_we_d;
    logic          s_rd_q,  s_rd_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    rdy_q,   rdy_d;
    logic [DW-1:0] spo_q,   spo_d;
    logic          err_q,   err_d;

    // ------------------------------------------------------------------------
    // Request vector and round-robin pick (search starts after last owner)
    // ------------------------------------------------------------------------
    logic [2:0]    req;
    logic          pick_vld;
    logic [1:0]    pick;
    logic [AW-1:0] pick_a;
    logic [DW-1:0] pick_d;
    logic          pick_we;
    logic [2:0]    grant_oh;

    assign req      = {m2_we | m2_rd, m1_we | m1_rd, m0_we | m0_rd};
    assign pick_vld = |req;

    always_comb begin
        pick = 2'd0;
        case (last_q)
            2'd0: begin
                if      (req[1]) pick = 2'd1;
                else if (req[2]) pick = 2'd2;
                else             pick = 2'd0;
            end
            2'd1: begin
                if      (req[2]) pick = 2'd2;
                else if (req[0]) pick = 2'd0;
                else             pick = 2'd1;
            end
            default: begin
                if      (req[0]) pick = 2'd0;
                else if (req[1]) pick = 2'd1;
                else             pick = 2'd2;
            end
        endcase
    end

    // Write takes precedence when a master raises both we and rd.
    always_comb begin
        pick_a  = m0_a;
        pick_d  = m0_d;
        pick_we = m0_we;
        case (pick)
            2'd1: begin
                pick_a  = m1_a;
                pick_d  = m1_d;
                pick_we = m1_we;
            end
            2'd2: begin
                pick_a  = m2_a;
                pick_d  = m2_d;
                pick_we = m2_we;
            end
            default: begin
                pick_a  = m0_a;
                pick_d  = m0_d;
                pick_we = m0_we;
            end
        endcase
    end

    always_comb begin
        grant_oh = 3'b000;
        case (grant_q)
            2'd0:    grant_oh = 3'b001;
            2'd1:    grant_oh = 3'b010;
            2'd2:    grant_oh = 3'b100;
            default: grant_oh = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        s_a_d   = s_a_q;
        s_d_d   = s_d_q;
        op_we_d = op_we_q;
        s_we_d  = 1'b0;
        s_rd_d  = 1'b0;
        cnt_d   = cnt_q;
        rdy_d   = 3'b000;
        spo_d   = '0;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    s_a_d   = pick_a;
                    s_d_d   = pick_d;
                    op_we_d = pick_we;
                    grant_d = pick;
                    last_d  = pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Strobes are registered, so they appear during the first
                // WAIT cycle and last exactly one cycle.
                s_we_d  = op_we_q;
                s_rd_d  = ~op_we_q;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != C_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // A real response wins over a coincident watchdog expiry.
                if (s_ready) begin
                    spo_d   = s_spo;
                    rdy_d   = grant_oh;
                    state_d = ST_DONE;
                end else if (cnt_q == C_LAST) begin
                    spo_d   = ERR_DATA;
                    rdy_d   = grant_oh;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Ready/spo fall back to zero via the defaults above.
                grant_d = C_IDLE_GRANT;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd2;
            grant_q <= C_IDLE_GRANT;
            s_a_q   <= '0;
            s_d_q   <= '0;
            op_we_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_rd_q  <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 3'b000;
            spo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            s_a_q   <= s_a_d;
            s_d_q   <= s_d_d;
            op_we_q <= op_we_d;
            s_we_q  <= s_we_d;
            s_rd_q  <= s_rd_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            spo_q   <= spo_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (read data gated so only the owning master sees it)
    // ------------------------------------------------------------------------
    assign m0_ready    = rdy_q[0];
    assign m1_ready    = rdy_q[1];
    assign m2_ready    = rdy_q[2];
    assign m0_spo      = rdy_q[0] ? spo_q : '0;
    assign m1_spo      = rdy_q[1] ? spo_q : '0;
    assign m2_spo      = rdy_q[2] ? spo_q : '0;
    assign s_a         = s_a_q;
    assign s_d         = s_d_q;
    assign s_we        = s_we_q;
    assign s_rd        = s_rd_q;
    assign timeout_err = err_q;
    assign grant       = grant_q;

endmodule
`default_nettype wire
